// File: rtl/key_pkg.sv
// Shared scan codes, FSM encoding and key lookup for the PS/2 command path.
package key_pkg;

  localparam logic [7:0] KC_EXT   = 8'hE0;
  localparam logic [7:0] KC_BRK   = 8'hF0;
  localparam logic [7:0] KC_UP    = 8'h75;
  localparam logic [7:0] KC_DOWN  = 8'h72;
  localparam logic [7:0] KC_RIGHT = 8'h74;
  localparam logic [7:0] KC_LEFT  = 8'h6B;
  localparam logic [7:0] KC_ENTER = 8'h5A;
  localparam logic [7:0] KC_SPACE = 8'h29;
  localparam logic [7:0] KC_ESC   = 8'h76;

  localparam int NUM_KEYS = 7;
  localparam int KI_UP    = 0;
  localparam int KI_DOWN  = 1;
  localparam int KI_RIGHT = 2;
  localparam int KI_LEFT  = 3;
  localparam int KI_ENTER = 4;
  localparam int KI_SPACE = 5;
  localparam int KI_ESC   = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } key_st_e;

  // Decoded byte leaving the prefix parser
  typedef struct packed {
    logic       make;
    logic       brk;
    logic [7:0] code;
  } key_ev_t;

  // One-hot slot of a command code; zero for unlisted codes
  function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [7:0] code);
    logic [NUM_KEYS-1:0] oh;
    oh = '0;
    case (code)
      KC_UP:    oh[KI_UP]    = 1'b1;
      KC_DOWN:  oh[KI_DOWN]  = 1'b1;
      KC_RIGHT: oh[KI_RIGHT] = 1'b1;
      KC_LEFT:  oh[KI_LEFT]  = 1'b1;
      KC_ENTER: oh[KI_ENTER] = 1'b1;
      KC_SPACE: oh[KI_SPACE] = 1'b1;
      KC_ESC:   oh[KI_ESC]   = 1'b1;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/key_prefix_timer.sv
// Idle-cycle counter for prefix states; expire asserts on the TIMEOUT_CYC-th idle cycle.
module key_prefix_timer #(
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  assign expire = en & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || restart || !en) cnt <= '0;
    else if (!expire)             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/key_command_ctrl.sv
// PS/2 scan-code parser turning E0/F0-prefixed byte streams into registered temperature commands.
module key_command_ctrl
  import key_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic [1:0] t_corp,
  output logic [1:0] t_amb,
  output logic       conect,
  output logic       selector_temp,
  output logic       rst_cmd,
  output logic       seq_err
);

  key_st_e             state, state_nxt;
  key_ev_t             ev;
  logic                err_nxt;
  logic                expire;
  logic [NUM_KEYS-1:0] pressed, pressed_nxt, hit, fresh;

  key_prefix_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state != ST_IDLE),
    .restart (key_valid),
    .expire  (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A byte arriving on the expiry cycle takes priority over the timeout
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    ev        = '0;
    ev.code   = key_code;
    if (key_valid) begin
      case (state)
        ST_IDLE: begin
          if (key_code == KC_EXT)      state_nxt = ST_EXT;
          else if (key_code == KC_BRK) state_nxt = ST_BRK;
          else                         ev.make   = 1'b1;
        end
        ST_EXT: begin
          if (key_code == KC_BRK)      state_nxt = ST_EXT_BRK;
          else if (key_code == KC_EXT) err_nxt   = 1'b1;
          else begin
            ev.make   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          if (key_code == KC_EXT || key_code == KC_BRK) err_nxt = 1'b1;
          else                                          ev.brk  = 1'b1;
        end
      endcase
    end else if (expire) begin
      err_nxt   = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  // fresh marks keys whose make arrives while not already held (ignores typematic repeat)
  always_comb begin
    hit         = key_onehot(ev.code);
    pressed_nxt = pressed;
    fresh       = '0;
    if (ev.make) begin
      fresh       = hit & ~pressed;
      pressed_nxt = pressed | hit;
    end else if (ev.brk) begin
      pressed_nxt = pressed & ~hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pressed       <= '0;
      t_corp        <= 2'b00;
      t_amb         <= 2'b00;
      conect        <= 1'b0;
      selector_temp <= 1'b0;
      rst_cmd       <= 1'b0;
      seq_err       <= 1'b0;
    end else begin
      pressed       <= pressed_nxt;
      t_corp        <= {pressed_nxt[KI_UP] & ~pressed_nxt[KI_DOWN],
                        pressed_nxt[KI_DOWN] & ~pressed_nxt[KI_UP]};
      t_amb         <= {pressed_nxt[KI_RIGHT] & ~pressed_nxt[KI_LEFT],
                        pressed_nxt[KI_LEFT] & ~pressed_nxt[KI_RIGHT]};
      conect        <= fresh[KI_ENTER];
      selector_temp <= selector_temp ^ fresh[KI_SPACE];
      rst_cmd       <= rst_cmd ^ fresh[KI_ESC];
      seq_err       <= err_nxt;
    end
  end

endmodule

// File: doc/key_command_ctrl.md
# key_command_ctrl

Sequences raw PS/2 scan-code bytes into debounced, registered temperature-control commands for the monitor datapath. Sits between the PS/2 byte receiver and the temperature selection/display logic. Parses E0/F0 prefixes and tracks press/release per command key. Generates level outputs for held keys and single-cycle or toggle outputs for one-shot keys, all on the system clock with no gated or derived clocks.

## Interface
- TIMEOUT_CYC, 50_000, cycles a prefix state may wait for its next byte before abandoning the sequence
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- key_code  in  8  scan-code byte from PS/2 receiver
- key_valid  in  1  one-cycle strobe, key_code valid this cycle
- t_corp  out  2  body-temp adjust: [1] up held (0x75), [0] down held (0x72)
- t_amb  out  2  ambient-temp adjust: [1] right held (0x74), [0] left held (0x6B)
- conect  out  1  one-cycle pulse on Enter (0x5A) press
- selector_temp  out  1  toggles on Space (0x29) press
- rst_cmd  out  1  toggles on Esc (0x76) press
- seq_err  out  1  one-cycle pulse on malformed prefix sequence or timeout

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE: E0 -> EXT; F0 -> BRK; other byte -> make event, stay IDLE.
- EXT: F0 -> EXT_BRK; E0 -> seq_err, stay EXT; other -> make event, -> IDLE.
- BRK / EXT_BRK: E0 or F0 -> seq_err, -> IDLE; other -> break event, -> IDLE.
- Extended and non-extended forms of a code are treated identically (arrow keys and keypad digits both act).
- Per-key pressed register for all seven command codes: set on make, cleared on break.
- Held keys (0x75, 0x72, 0x74, 0x6B): outputs follow pressed register.
- Opposite directions held together (0x75 and 0x72, or 0x74 and 0x6B): that pair outputs 2'b00 until one is released.
- One-shot keys (0x5A, 0x29, 0x76): act only on make while pressed bit is clear. Typematic repeat makes do not re-pulse or re-toggle. Break clears the pressed bit and produces no output action.
- Unlisted codes: prefix parsing proceeds normally; no output effect.
- Timeout counter runs only in EXT, BRK and EXT_BRK, and restarts on every key_valid. Reaching TIMEOUT_CYC-1 produces seq_err and a return to IDLE.
- key_valid low: FSM holds except for the timeout path.

## Timing
- Reset (rst_n low at clk edge): state IDLE, pressed bits 0, t_corp=00, t_amb=00, conect=0, selector_temp=0, rst_cmd=0, seq_err=0, timeout counter 0.
- All outputs are registered. Latency is 1 cycle from the key_valid edge carrying the final byte of a sequence to the output change.
- conect and seq_err are high for exactly one cycle.
- key_valid is accepted on back-to-back cycles with no gap required.
- Reset mid-sequence (for example after E0) discards the prefix. The next byte is parsed from IDLE.
- A timeout and a key_valid on the same cycle: key_valid wins, the byte is parsed, and no seq_err is raised.

## Structure
- Shared package key_pkg:
  - scan-code localparams: KC_EXT=0xE0, KC_BRK=0xF0, KC_UP=0x75, KC_DOWN=0x72, KC_RIGHT=0x74, KC_LEFT=0x6B, KC_ENTER=0x5A, KC_SPACE=0x29, KC_ESC=0x76
  - FSM state encoding
- One sub-module: key_prefix_timer, a TIMEOUT_CYC counter with restart and enable inputs and an expire output.
- Top level contains the prefix FSM, the pressed-bit register file, and the output registers.

## Test plan
- Reset, then send 0x75 -> t_corp=10 one cycle later. Send F0,75 -> t_corp=00.
- Send E0,75, then 72 -> t_corp=00 while both are held. Send F0,72 -> t_corp=10.
- Send 5A,5A,5A (typematic) -> conect pulses once for one cycle. Send F0,5A, then 5A -> a second pulse.
- Send 29 twice with F0,29 between -> selector_temp goes 0->1->0. Repeat with 76 -> rst_cmd toggles likewise.
- Send F0,F0 -> seq_err pulse, FSM returns to IDLE. Then send 74 -> t_amb=10.
- Send E0, wait TIMEOUT_CYC cycles -> seq_err pulse. Then send 6B -> t_amb=01. Assert rst_n after E0 -> all outputs 0, and the next byte is parsed as a make.
